vend_transaction_ctrl: RTL and testbench

Transaction sequencer for the vending machine. Accepts coin/note events and product selections, looks up each product's price, applies the loyalty discount, and checks credit. It then issues a one-cycle dispense command and returns change one coin per cycle. It sits above the money-counting and price-lookup datapath and owns the machine's credit register and the only path to the dispense/change actuators.

---
 rtl/vend_pkg.sv | 46 ++++
 rtl/vend_change_dispenser.sv | 55 +++++
 rtl/vend_transaction_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_transaction_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer:
// FSM states, one-hot coin encodings with their values, and error codes.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_PRICE,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE
    } vend_state_t;

    localparam logic [3:0] COIN_500  = 4'b0001;
    localparam logic [3:0] COIN_1000 = 4'b0010;
    localparam logic [3:0] COIN_2000 = 4'b0100;
    localparam logic [3:0] COIN_5000 = 4'b1000;

    localparam logic [15:0] VALUE_500  = 16'd500;
    localparam logic [15:0] VALUE_1000 = 16'd1000;
    localparam logic [15:0] VALUE_2000 = 16'd2000;
    localparam logic [15:0] VALUE_5000 = 16'd5000;

    localparam logic [3:0] ERR_NONE         = 4'h0;
    localparam logic [3:0] ERR_INSUFFICIENT = 4'h1;
    localparam logic [3:0] ERR_OVER_LIMIT   = 4'h2;
    localparam logic [3:0] ERR_SOLD_OUT     = 4'h3;
    localparam logic [3:0] ERR_BUSY         = 4'h4;
    localparam logic [3:0] ERR_INVALID      = 4'hF;

    // A zero return marks a money_type that is not exactly one-hot.
    function automatic logic [15:0] money_value(input logic [3:0] coin);
        case (coin)
            COIN_500:  return VALUE_500;
            COIN_1000: return VALUE_1000;
            COIN_2000: return VALUE_2000;
            COIN_5000: return VALUE_5000;
            default:   return 16'd0;
        endcase
    endfunction

    function automatic vend_state_t rest_state(input logic [15:0] amount);
        return (amount != 16'd0) ? ST_CREDIT : ST_IDLE;
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change stepper: each step emits the largest coin not exceeding the
// presented amount and reports what is left and whether another coin fits.
module vend_change_dispenser
    import vend_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_step,
    input  logic [15:0] i_amount,
    output logic        o_change_valid,
    output logic [3:0]  o_change_type,
    output logic [15:0] o_residual,
    output logic        o_done
);

    logic [3:0]  w_coin_type;
    logic [15:0] w_coin_value;
    logic        r_change_valid;
    logic [3:0]  r_change_type;

    always_comb begin
        w_coin_type  = 4'b0000;
        w_coin_value = 16'd0;
        if (i_amount >= VALUE_5000) begin
            w_coin_type  = COIN_5000;
            w_coin_value = VALUE_5000;
        end else if (i_amount >= VALUE_2000) begin
            w_coin_type  = COIN_2000;
            w_coin_value = VALUE_2000;
        end else if (i_amount >= VALUE_1000) begin
            w_coin_type  = COIN_1000;
            w_coin_value = VALUE_1000;
        end else if (i_amount >= VALUE_500) begin
            w_coin_type  = COIN_500;
            w_coin_value = VALUE_500;
        end
    end

    assign o_residual = i_amount - w_coin_value;
    assign o_done     = (o_residual < VALUE_500);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_change_valid <= 1'b0;
            r_change_type  <= 4'b0000;
        end else begin
            r_change_valid <= i_step && (w_coin_type != 4'b0000);
            r_change_type  <= i_step ? w_coin_type : 4'b0000;
        end
    end

    assign o_change_valid = r_change_valid;
    assign o_change_type  = r_change_type;

endmodule

// File: rtl/vend_transaction_ctrl.sv
// Vending transaction sequencer: owns credit, prices and discounts the
// selected product, issues the dispense pulse and drives change return.
module vend_transaction_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_STEP         = 500,
    parameter int unsigned MAX_CREDIT         = 20000,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned DISCOUNT_THRESHOLD = 10
)
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_money_valid,
    input  logic [3:0]  i_money_type,
    input  logic        i_select_valid,
    input  logic [2:0]  i_address,
    input  logic        i_cancel,
    input  logic [7:0]  i_stock_empty,
    output logic [15:0] o_credit,
    output logic [3:0]  o_error,
    output logic        o_busy,
    output logic        o_dispense_valid,
    output logic [2:0]  o_dispense_addr,
    output logic        o_change_valid,
    output logic [3:0]  o_change_type,
    output logic [7:0]  o_sales_count
);

    vend_state_t r_state, w_next_state;
    logic [15:0] r_credit, w_next_credit;
    logic [3:0]  r_error, w_next_error;
    logic [2:0]  r_addr, w_next_addr;
    logic [15:0] r_price, w_next_price;
    logic [7:0]  r_sales, w_next_sales;
    logic [7:0]  r_timer, w_next_timer;
    logic        r_busy, w_next_busy;
    logic        r_dispense_valid, w_next_dispense_valid;
    logic        w_change_step;

    logic [15:0] w_coin_value;
    logic [16:0] w_credit_sum;
    logic [15:0] w_base, w_scaled, w_discounted, w_after_sale;
    logic [15:0] w_residual;
    logic        w_change_done;

    assign w_coin_value = money_value(i_money_type);
    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_value};
    assign w_base       = 16'(PRICE_STEP) * (16'(r_addr) + 16'd1);
    // ceil(base*9/16): round up whenever any fractional bits are shifted out
    assign w_scaled     = (w_base << 3) + w_base;
    assign w_discounted = (w_scaled >> 4) + {15'd0, |w_scaled[3:0]};
    assign w_after_sale = r_credit - r_price;

    vend_change_dispenser u_change (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_step         (w_change_step),
        .i_amount       (r_credit),
        .o_change_valid (o_change_valid),
        .o_change_type  (o_change_type),
        .o_residual     (w_residual),
        .o_done         (w_change_done)
    );

    always_comb begin
        w_next_state          = r_state;
        w_next_credit         = r_credit;
        w_next_error          = r_error;
        w_next_addr           = r_addr;
        w_next_price          = r_price;
        w_next_sales          = r_sales;
        w_next_timer          = 8'd0;
        w_next_dispense_valid = 1'b0;
        w_change_step         = 1'b0;

        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                if (i_cancel) begin
                    if (r_credit != 16'd0) w_next_state = ST_CHANGE;
                end else if (i_money_valid) begin
                    if (w_coin_value == 16'd0) begin
                        w_next_error = ERR_INVALID;
                    end else if (w_credit_sum > 17'(MAX_CREDIT)) begin
                        w_next_error = ERR_OVER_LIMIT;
                    end else begin
                        w_next_credit = w_credit_sum[15:0];
                        w_next_error  = ERR_NONE;
                        w_next_state  = ST_CREDIT;
                    end
                end else if (i_select_valid) begin
                    if (i_stock_empty[i_address]) begin
                        w_next_error = ERR_SOLD_OUT;
                    end else begin
                        w_next_addr  = i_address;
                        w_next_state = ST_PRICE;
                    end
                end else if (r_state == ST_CREDIT && r_credit >= VALUE_500) begin
                    // Only uninterrupted idle cycles holding refundable credit count
                    if (r_timer == 8'(TIMEOUT_CYCLES - 1)) begin
                        w_next_state = ST_CHANGE;
                    end else begin
                        w_next_timer = r_timer + 8'd1;
                    end
                end
            end
            ST_PRICE: begin
                w_next_price = (r_sales > 8'(DISCOUNT_THRESHOLD)) ? w_discounted : w_base;
                w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_credit >= r_price) begin
                    w_next_state          = ST_DISPENSE;
                    w_next_dispense_valid = 1'b1;
                end else begin
                    w_next_error = ERR_INSUFFICIENT;
                    w_next_state = rest_state(r_credit);
                end
            end
            ST_DISPENSE: begin
                w_next_credit = w_after_sale;
                w_next_sales  = (r_sales == 8'hFF) ? r_sales : r_sales + 8'd1;
                w_next_error  = ERR_NONE;
                w_next_state  = (w_after_sale >= VALUE_500) ? ST_CHANGE : rest_state(w_after_sale);
            end
            ST_CHANGE: begin
                w_change_step = 1'b1;
                w_next_credit = w_residual;
                if (w_change_done) w_next_state = rest_state(w_residual);
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (r_busy && i_money_valid) w_next_error = ERR_BUSY;

        w_next_busy = (w_next_state == ST_PRICE) || (w_next_state == ST_CHECK) ||
                      (w_next_state == ST_DISPENSE) || (w_next_state == ST_CHANGE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_credit         <= 16'd0;
            r_error          <= ERR_NONE;
            r_addr           <= 3'd0;
            r_price          <= 16'd0;
            r_sales          <= 8'd0;
            r_timer          <= 8'd0;
            r_busy           <= 1'b0;
            r_dispense_valid <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_credit         <= w_next_credit;
            r_error          <= w_next_error;
            r_addr           <= w_next_addr;
            r_price          <= w_next_price;
            r_sales          <= w_next_sales;
            r_timer          <= w_next_timer;
            r_busy           <= w_next_busy;
            r_dispense_valid <= w_next_dispense_valid;
        end
    end

    assign o_credit         = r_credit;
    assign o_error          = r_error;
    assign o_busy           = r_busy;
    assign o_dispense_valid = r_dispense_valid;
    assign o_dispense_addr  = r_addr;
    assign o_sales_count    = r_sales;

endmodule

// File: tb/tb_vend_transaction_ctrl.sv
// Directed bench for vend_transaction_ctrl; dispense and change pulses are
// matched against scoreboard queues filled as each transaction is started.
module tb_vend_transaction_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        moneyValid;
    logic [3:0]  moneyType;
    logic        selectValid;
    logic [2:0]  address;
    logic        cancel;
    logic [7:0]  stockEmpty;
    logic [15:0] credit;
    logic [3:0]  errorCode;
    logic        busy;
    logic        dispenseValid;
    logic [2:0]  dispenseAddr;
    logic        changeValid;
    logic [3:0]  changeType;
    logic [7:0]  salesCount;

    int checks = 0;
    int failures = 0;
    logic [2:0] expDisp[$];
    logic [3:0] expChange[$];

    vend_transaction_ctrl dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_money_valid    (moneyValid),
        .i_money_type     (moneyType),
        .i_select_valid   (selectValid),
        .i_address        (address),
        .i_cancel         (cancel),
        .i_stock_empty    (stockEmpty),
        .o_credit         (credit),
        .o_error          (errorCode),
        .o_busy           (busy),
        .o_dispense_valid (dispenseValid),
        .o_dispense_addr  (dispenseAddr),
        .o_change_valid   (changeValid),
        .o_change_type    (changeType),
        .o_sales_count    (salesCount)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and retire any dispense/change pulse against the scoreboard
    task automatic tick();
        @(posedge clock);
        #1;
        if (dispenseValid) begin
            if (expDisp.size() == 0) checkOutput("disp_unexpected", 32'd1, 32'd0);
            else checkOutput("disp_addr", 32'(dispenseAddr), 32'(expDisp.pop_front()));
        end
        if (changeValid) begin
            if (expChange.size() == 0) checkOutput("change_unexpected", 32'd1, 32'd0);
            else checkOutput("change_type", 32'(changeType), 32'(expChange.pop_front()));
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [3:0] mt, input logic sv,
                                 input logic [2:0] adr, input logic cn);
        moneyValid  = mv;
        moneyType   = mt;
        selectValid = sv;
        address     = adr;
        cancel      = cn;
        tick();
        moneyValid  = 1'b0;
        selectValid = 1'b0;
        cancel      = 1'b0;
    endtask

    task automatic coin(input logic [3:0] mt);
        applyStimulus(1'b1, mt, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic selectProduct(input logic [2:0] adr);
        applyStimulus(1'b0, 4'b0000, 1'b1, adr, 1'b0);
    endtask

    task automatic doCancel();
        applyStimulus(1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        moneyValid = 1'b0; moneyType = 4'b0000; selectValid = 1'b0;
        address = 3'd0; cancel = 1'b0; stockEmpty = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_credit", 32'(credit), 32'd0);
        checkOutput("reset_error", 32'(errorCode), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sales", 32'(salesCount), 32'd0);
        checkOutput("reset_disp_addr", 32'(dispenseAddr), 32'd0);

        $display("[TB] basic sale with change");
        coin(4'b0010);
        checkOutput("credit_1000", 32'(credit), 32'd1000);
        coin(4'b0100);
        checkOutput("credit_3000", 32'(credit), 32'd3000);
        expDisp.push_back(3'd3);
        expChange.push_back(4'b0010);
        selectProduct(3'd3);
        checkOutput("busy_after_select", 32'(busy), 32'd1);
        tick();
        checkOutput("no_disp_yet", 32'(dispenseValid), 32'd0);
        tick();
        checkOutput("disp_timing", 32'(dispenseValid), 32'd1);
        tick();
        checkOutput("credit_after_sale", 32'(credit), 32'd1000);
        tick();
        checkOutput("credit_after_change", 32'(credit), 32'd0);
        checkOutput("busy_done", 32'(busy), 32'd0);
        checkOutput("sales_1", 32'(salesCount), 32'd1);

        $display("[TB] insufficient credit");
        coin(4'b0001);
        selectProduct(3'd1);
        tick(); tick();
        checkOutput("err_insufficient", 32'(errorCode), 32'h1);
        checkOutput("credit_kept", 32'(credit), 32'd500);
        checkOutput("busy_fell", 32'(busy), 32'd0);
        expChange.push_back(4'b0001);
        doCancel();
        tick();
        checkOutput("credit_refunded", 32'(credit), 32'd0);

        $display("[TB] error codes");
        coin(4'b0011);
        checkOutput("err_invalid", 32'(errorCode), 32'hF);
        checkOutput("credit_invalid", 32'(credit), 32'd0);
        coin(4'b0010);
        checkOutput("err_cleared", 32'(errorCode), 32'h0);
        stockEmpty = 8'b0000_0100;
        selectProduct(3'd2);
        checkOutput("err_sold_out", 32'(errorCode), 32'h3);
        checkOutput("sold_out_not_busy", 32'(busy), 32'd0);
        stockEmpty = 8'h00;
        expDisp.push_back(3'd0);
        expChange.push_back(4'b0001);
        selectProduct(3'd0);
        coin(4'b0001);
        checkOutput("err_busy", 32'(errorCode), 32'h4);
        checkOutput("credit_busy_coin", 32'(credit), 32'd1000);
        tick(); tick();
        checkOutput("credit_busy_sale", 32'(credit), 32'd500);
        tick();
        checkOutput("credit_busy_end", 32'(credit), 32'd0);

        $display("[TB] credit limit");
        repeat (4) coin(4'b1000);
        checkOutput("credit_max", 32'(credit), 32'd20000);
        coin(4'b0001);
        checkOutput("err_over_limit", 32'(errorCode), 32'h2);
        checkOutput("credit_over_limit", 32'(credit), 32'd20000);
        repeat (4) expChange.push_back(4'b1000);
        doCancel();
        repeat (4) tick();
        checkOutput("credit_limit_refund", 32'(credit), 32'd0);

        $display("[TB] cancel refund");
        coin(4'b1000); coin(4'b0100); coin(4'b0001);
        expChange.push_back(4'b1000);
        expChange.push_back(4'b0100);
        expChange.push_back(4'b0001);
        doCancel();
        repeat (3) tick();
        checkOutput("credit_cancel", 32'(credit), 32'd0);
        checkOutput("change_queue_empty", 32'(expChange.size()), 32'd0);

        $display("[TB] timeout refund");
        coin(4'b0010); coin(4'b0001);
        repeat (254) tick();
        checkOutput("timeout_not_yet", 32'(busy), 32'd0);
        expChange.push_back(4'b0010);
        expChange.push_back(4'b0001);
        tick();
        checkOutput("timeout_busy", 32'(busy), 32'd1);
        tick(); tick();
        checkOutput("timeout_credit", 32'(credit), 32'd0);
        checkOutput("timeout_queue_empty", 32'(expChange.size()), 32'd0);

        $display("[TB] discount");
        repeat (9) begin
            expDisp.push_back(3'd0);
            coin(4'b0001);
            selectProduct(3'd0);
            repeat (3) tick();
        end
        checkOutput("sales_11", 32'(salesCount), 32'd11);
        coin(4'b0010);
        expDisp.push_back(3'd0);
        expChange.push_back(4'b0001);
        selectProduct(3'd0);
        repeat (3) tick();
        checkOutput("credit_discounted", 32'(credit), 32'd718);
        tick();
        checkOutput("credit_residual", 32'(credit), 32'd218);
        checkOutput("residual_not_busy", 32'(busy), 32'd0);
        checkOutput("sales_12", 32'(salesCount), 32'd12);

        $display("[TB] reset during change");
        coin(4'b1000); coin(4'b1000);
        expChange.push_back(4'b1000);
        expChange.push_back(4'b1000);
        doCancel();
        tick();
        checkOutput("first_pulse_consumed", 32'(expChange.size()), 32'd1);
        reset = 1'b1;
        #1;
        expChange.delete();
        checkOutput("rst_credit", 32'(credit), 32'd0);
        checkOutput("rst_change_valid", 32'(changeValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sales", 32'(salesCount), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("post_rst_credit", 32'(credit), 32'd0);
        checkOutput("post_rst_change", 32'(changeValid), 32'd0);
        checkOutput("disp_queue_empty", 32'(expDisp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
